// File: rtl/vga_scan_ctrl.sv
// VGA scan-out sequencer: raster timing, frame-buffer addressing and
// sync/enable delay matched to the frame-buffer read latency.
module vga_scan_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PIXEL_DEPTH = 8,
  parameter int RAM_LATENCY = 1,
  parameter int SCALE_SHIFT = 0,
  localparam int FB_W = H_ACTIVE >> SCALE_SHIFT,
  localparam int FB_H = V_ACTIVE >> SCALE_SHIFT,
  localparam int PIXEL_ADDR_WIDTH = $clog2(FB_W * FB_H),
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int D = RAM_LATENCY + 2
) (
  input  logic                        pxclk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [PIXEL_ADDR_WIDTH-1:0] px_addr,
  input  logic [PIXEL_DEPTH-1:0]      px_data,
  output logic [PIXEL_DEPTH-1:0]      vga_pixel,
  output logic                        vga_hsync,
  output logic                        vga_vsync,
  output logic                        vga_de,
  output logic                        frame_start,
  output logic                        vblank
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = PIXEL_ADDR_WIDTH;
  localparam int PD = D - 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);

  localparam logic [AW:0] LB_STEP = (AW + 1)'(FB_W);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [AW:0]   line_base;

  logic          h_end;
  logic          v_end;
  logic          active;
  logic          hs;
  logic          vs;
  logic          first;
  logic          vb;
  logic          line_step;
  logic [AW-1:0] addr_next;

  logic [PD-1:0] de_p;
  logic [PD-1:0] hs_p;
  logic [PD-1:0] vs_p;
  logic [PD-1:0] fs_p;
  logic [PD-1:0] vb_p;

  assign h_end  = h_cnt == H_LAST;
  assign v_end  = v_cnt == V_LAST;
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs     = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
  assign vs     = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);
  assign first  = (h_cnt == '0) && (v_cnt == '0) && en;
  assign vb     = v_cnt >= V_ACT;

  // Base advances after the last replicated copy of each buffer line.
  assign line_step = h_end
                  && ((v_cnt & V_MASK) == V_MASK)
                  && (v_cnt < V_ACT);

  assign addr_next = line_base[AW-1:0]
                   + AW'(h_cnt >> SCALE_SHIFT);

  always_ff @(posedge pxclk) begin
    if (!rst_n || !en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_base   <= '0;
      px_addr     <= '0;
      de_p        <= '0;
      hs_p        <= '0;
      vs_p        <= '0;
      fs_p        <= '0;
      vb_p        <= '0;
      vga_pixel   <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + HW'(1);
      if (h_end)
        v_cnt <= v_end ? '0 : v_cnt + VW'(1);

      if (h_end && v_end)
        line_base <= '0;
      else if (line_step)
        line_base <= line_base + LB_STEP;

      px_addr <= active ? addr_next : '0;

      de_p[0] <= active;
      hs_p[0] <= hs;
      vs_p[0] <= vs;
      fs_p[0] <= first;
      vb_p[0] <= vb;
      for (int i = 1; i < PD; i++) begin
        de_p[i] <= de_p[i-1];
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        fs_p[i] <= fs_p[i-1];
        vb_p[i] <= vb_p[i-1];
      end

      vga_pixel   <= de_p[PD-1] ? px_data : '0;
      vga_hsync   <= ~hs_p[PD-1];
      vga_vsync   <= ~vs_p[PD-1];
      vga_de      <= de_p[PD-1];
      frame_start <= fs_p[PD-1];
      vblank      <= vb_p[PD-1];
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Scan-out sequencer for the VGA frame buffer read port (port A, pxclk domain).
- Generates raster timing and issues one pixel address per pxclk to the frame buffer.
- Delays sync/blank/data-enable to line up with the RAM read latency, so the pixel, syncs and enable leave the block on the same cycle.
- Supports integer power-of-two pixel replication, so a smaller frame buffer can fill the full raster.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pxclk)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIXEL_DEPTH, 8, bits per pixel
- RAM_LATENCY, 1, pxclk cycles from px_addr to valid px_data
- SCALE_SHIFT, 0, replication factor 2^SCALE_SHIFT in both axes
- Derived (localparam): FB_W=H_ACTIVE>>SCALE_SHIFT, FB_H=V_ACTIVE>>SCALE_SHIFT, PIXEL_ADDR_WIDTH=$clog2(FB_W*FB_H), H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise, D=RAM_LATENCY+2

Ports:
- pxclk, input, 1, pixel clock
- rst_n, input, 1, reset, synchronous, active-low
- en, input, 1, scan enable
- px_addr, output, PIXEL_ADDR_WIDTH, frame-buffer pixel address (registered)
- px_data, input, PIXEL_DEPTH, frame-buffer read data
- vga_pixel, output, PIXEL_DEPTH, pixel to DAC/pins (registered)
- vga_hsync, output, 1, horizontal sync, active-low
- vga_vsync, output, 1, vertical sync, active-low
- vga_de, output, 1, data enable (active video)
- frame_start, output, 1, single-cycle pulse with first active pixel of a frame
- vblank, output, 1, high while output stage is in vertical blanking

Behaviour:
- Reset (rst_n=0 at pxclk edge):
  - h_cnt=v_cnt=0; pipeline cleared; px_addr=0.
  - Outputs: vga_hsync=1, vga_vsync=1, vga_de=0, vga_pixel=0, frame_start=0, vblank=0.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - On wrap, v_cnt increments 0..V_TOTAL-1 and wraps to 0.
  - Counters advance only while en=1. en=0 forces h_cnt=v_cnt=0 on the next edge.
- Position P=(h_cnt,v_cnt):
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
- Address (stage 1):
  - px_addr <= active ? (v>>SCALE_SHIFT)*FB_W + (h>>SCALE_SHIFT) : 0
  - Implement with a line-base register plus column counter; no multiplier.
  - Line base += FB_W at end of each line where (v & (2^SCALE_SHIFT-1)) == 2^SCALE_SHIFT-1 and v<V_ACTIVE.
  - Line base clears at frame wrap.
- Alignment:
  - active, hs, vs and first-pixel flag (h==0 && v==0 && en) ride a shift pipe of depth D-1.
  - Position P's outputs appear exactly D cycles after P was counted.
  - vga_pixel <= de_pipe ? px_data : 0.
  - vga_hsync <= ~hs_pipe, vga_vsync <= ~vs_pipe, vga_de <= de_pipe.
  - frame_start <= first_pipe; vblank <= vblank_pipe (v>=V_ACTIVE).
- en deassertion:
  - All pipe stages clear synchronously on the same edge as the counter reset.
  - Outputs show the reset values one cycle after en falls; no partial tail.
- en assertion: counting begins at (0,0) on the first edge with en=1; frame_start follows D cycles later.
- Reset mid-frame: identical to en deassertion; outputs idle on the next cycle.
- Scaling: each buffer pixel repeats for 2^SCALE_SHIFT consecutive pxclk, and each buffer line for 2^SCALE_SHIFT consecutive lines.
- Last address: the last active pixel of a frame is FB_W*FB_H-1. px_addr never exceeds it.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, RAM_LATENCY 1, SCALE_SHIFT 0), rst_n low 3 cycles then en=1:
  - hsync low for 2 cycles every 14.
  - vsync low for exactly 1 line (14 cycles) every 7 lines.
  - vga_de high 8 cycles per line on lines 0-3 only.
- Same config, RAM model returns data=address:
  - vga_pixel sequence per frame is 0..31 in order.
  - frame_start pulses coincident with pixel 0, 3 cycles after counter (0,0).
- SCALE_SHIFT=1 (FB 4x2), same raster:
  - Line 0 addresses 0,0,1,1,2,2,3,3; line 1 identical.
  - Line 2 gives 4,4,5,5,6,6,7,7; max address 7.
- RAM_LATENCY=3:
  - hsync/de edges shift to D=5 cycles after counter position.
  - Pixel and de remain aligned (pixel 0 appears with the first de).
- Drop en mid-line (h=5, v=2):
  - Next cycle: de=0, hsync=vsync=1, px_addr=0, no frame_start.
  - Re-raise en: full frame restarts at (0,0).
- Assert rst_n=0 for 1 cycle during vsync: outputs at reset values the next cycle, and timing restarts cleanly.
